// File: rtl/hdmi_ser_ctrl.sv
// Purpose: HDMI serializer bring-up controller: lock qualification, serializer reset, CTL0 warm-up, then video pass-through.
// Latency: tmds_in reaches tmds_internal one clk_pixel cycle later while in RUN; all outputs are registered.
// Backpressure: none; the link drops to IDLE on the next edge whenever pll_lock or enable goes low.
module hdmi_ser_ctrl #(
    parameter int unsigned LOCK_CYCLES    = 1024,
    parameter int unsigned SER_RST_CYCLES = 16,
    parameter int unsigned WARMUP_CYCLES  = 64,
    parameter bit          INVERT         = 1'b0
) (
    input  logic            clk_pixel,
    input  logic            reset_n,
    input  logic            pll_lock,
    input  logic            enable,
    input  logic [2:0][9:0] tmds_in,
    output logic [2:0][9:0] tmds_internal,
    output logic            ser_reset,
    output logic            link_up,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_SER_RST   = 3'd2,
        ST_WARMUP    = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // CTL0 control token; the mask folds the optional board pair-swap inversion into every word.
    localparam logic [9:0]  CTL0      = 10'b1101010100;
    localparam logic [9:0]  INV_MASK  = INVERT ? 10'h3FF : 10'h000;
    localparam logic [9:0]  CTL0_OUT  = CTL0 ^ INV_MASK;
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] SRST_LAST = 16'(SER_RST_CYCLES - 1);
    localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0][9:0] tmds_q, tmds_d;
    logic            ser_reset_q, ser_reset_d;
    logic            link_up_q, link_up_d;
    logic            link_ok;

    assign link_ok = enable & pll_lock;

    // Next-state decode: sequence timing, with loss of lock/enable overriding everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (link_ok) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_WAIT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = ST_SER_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SER_RST: begin
                if (cnt_q == SRST_LAST) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_q != ST_IDLE) && !link_ok) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs decoded from the same next state so they always agree with the state register.
    always_comb begin
        ser_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOCK_WAIT) || (state_d == ST_SER_RST);
        link_up_d   = (state_d == ST_RUN);
        for (int ch = 0; ch < 3; ch++) begin
            tmds_d[ch] = (state_d == ST_RUN) ? (tmds_in[ch] ^ INV_MASK) : CTL0_OUT;
        end
    end

    // State, counter and output registers; reset parks the link in IDLE with the serializer held in reset.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ser_reset_q <= 1'b1;
            link_up_q   <= 1'b0;
            tmds_q      <= {3{CTL0_OUT}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ser_reset_q <= ser_reset_d;
            link_up_q   <= link_up_d;
            tmds_q      <= tmds_d;
        end
    end

    assign tmds_internal = tmds_q;
    assign ser_reset     = ser_reset_q;
    assign link_up       = link_up_q;
    assign state         = state_q;

endmodule

// File: tb/tb_hdmi_ser_ctrl.sv
// Purpose: bench for hdmi_ser_ctrl, plain and inverted instances driven from the same inputs.
// Latency: expected outputs follow from elapsed cycles since lock qualification began.
// Backpressure: none; the bench drives every cycle.
module tb_hdmi_ser_ctrl;

    localparam int L = 8;
    localparam int S = 4;
    localparam int W = 5;
    localparam logic [9:0] CTL0 = 10'b1101010100;

    logic            clk_pixel = 1'b0;
    logic            reset_n   = 1'b0;
    logic            pll_lock  = 1'b0;
    logic            enable    = 1'b0;
    logic [2:0][9:0] tmds_in   = '0;
    logic [2:0][9:0] tmds_internal, tmds_internal_inv;
    logic            ser_reset, ser_reset_inv, link_up, link_up_inv;
    logic [2:0]      state, state_inv;

    int checks = 0;
    int errors = 0;

    // Reference: link is either inactive (IDLE) or m_t cycles past the start of lock qualification.
    bit              m_active = 1'b0;
    int              m_t      = 0;
    logic [2:0][9:0] m_tin    = '0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_ser_ctrl #(.LOCK_CYCLES(L), .SER_RST_CYCLES(S), .WARMUP_CYCLES(W), .INVERT(1'b0)) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .pll_lock(pll_lock), .enable(enable),
        .tmds_in(tmds_in), .tmds_internal(tmds_internal), .ser_reset(ser_reset),
        .link_up(link_up), .state(state)
    );

    hdmi_ser_ctrl #(.LOCK_CYCLES(L), .SER_RST_CYCLES(S), .WARMUP_CYCLES(W), .INVERT(1'b1)) dut_inv (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .pll_lock(pll_lock), .enable(enable),
        .tmds_in(tmds_in), .tmds_internal(tmds_internal_inv), .ser_reset(ser_reset_inv),
        .link_up(link_up_inv), .state(state_inv)
    );

    wire [69:0] obs = {state, ser_reset, link_up, tmds_internal,
                       state_inv, ser_reset_inv, link_up_inv, tmds_internal_inv};

    function automatic logic [2:0] exp_state();
        if (!m_active)            return 3'd0;
        else if (m_t < L)         return 3'd1;
        else if (m_t < L + S)     return 3'd2;
        else if (m_t < L + S + W) return 3'd3;
        else                      return 3'd4;
    endfunction

    function automatic logic [69:0] exp_vec();
        logic [2:0]      s;
        logic [2:0][9:0] w;
        s = exp_state();
        for (int ch = 0; ch < 3; ch++) w[ch] = (s == 3'd4) ? m_tin[ch] : CTL0;
        return {s, (s < 3'd3), (s == 3'd4), w, s, (s < 3'd3), (s == 3'd4), ~w};
    endfunction

    function automatic logic [2:0][9:0] rnd_words();
        return 30'($urandom);
    endfunction

    // One clk_pixel cycle of stimulus; the model advances at the edge, outputs settle by the negedge.
    task automatic drive(input logic en, input logic lk, input logic [2:0][9:0] tin);
        enable   = en;
        pll_lock = lk;
        tmds_in  = tin;
        @(posedge clk_pixel);
        if (!m_active) begin
            if (en && lk) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (!(en && lk)) begin
            m_active = 1'b0;
        end else if (m_t < 1000) begin
            m_t++;
        end
        m_tin = tin;
        @(negedge clk_pixel);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", obs, exp_vec());
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive((i >= 3), (i < 3), rnd_words());
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL idle_hold cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_bringup();
        int n_lw = 0, n_sr = 0, n_wu = 0;
        logic [2:0][9:0] tin;
        for (int i = 0; i < 24; i++) begin
            tin = rnd_words();
            if (i == 19) tin = {10'h3FF, 10'h155, 10'h2AA};
            drive(1'b1, 1'b1, tin);
            if (state == 3'd1) n_lw++;
            if (state == 3'd2 && ser_reset) n_sr++;
            if (state == 3'd3) n_wu++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL bringup cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (n_lw != L || n_sr != S || n_wu != W) begin
            errors++;
            $display("FAIL bringup_durations: got lw=%0d sr=%0d wu=%0d want %0d %0d %0d", n_lw, n_sr, n_wu, L, S, W);
        end
    endtask

    task automatic test_run_loss();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, rnd_words());
            checks++;
            if (obs !== exp_vec() || tmds_internal !== {3{CTL0}} || link_up !== 1'b0) begin
                errors++;
                $display("FAIL run_loss cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_lock_glitch();
        int n_lw = 0;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, rnd_words());
        drive(1'b1, 1'b0, rnd_words());
        checks++;
        if (obs !== exp_vec() || state !== 3'd0) begin
            errors++;
            $display("FAIL lock_glitch_drop: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, rnd_words());
            if (state == 3'd1) n_lw++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL lock_glitch cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (n_lw != L) begin
            errors++;
            $display("FAIL lock_glitch_requal: got %0d lock-wait cycles want %0d", n_lw, L);
        end
    endtask

    task automatic test_enable_warmup();
        int n_lw = 0, n_sr = 0, n_wu = 0;
        drive(1'b0, 1'b1, rnd_words());
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, rnd_words());
        drive(1'b0, 1'b1, rnd_words());
        checks++;
        if (obs !== exp_vec() || state !== 3'd0) begin
            errors++;
            $display("FAIL warmup_disable: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, rnd_words());
            if (state == 3'd1) n_lw++;
            if (state == 3'd2) n_sr++;
            if (state == 3'd3) n_wu++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL warmup_restart cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (n_lw != L || n_sr != S || n_wu != W || link_up !== 1'b1) begin
            errors++;
            $display("FAIL warmup_repeat: got lw=%0d sr=%0d wu=%0d up=%b want %0d %0d %0d 1", n_lw, n_sr, n_wu, link_up, L, S, W);
        end
    endtask

    task automatic test_invert();
        logic [2:0][9:0] tin;
        tin    = rnd_words();
        tin[0] = 10'h0F0;
        drive(1'b1, 1'b1, tin);
        checks++;
        if (tmds_internal_inv[0] !== 10'h30F || tmds_internal[0] !== 10'h0F0) begin
            errors++;
            $display("FAIL invert_video: got %h/%h want 30f/0f0", tmds_internal_inv[0], tmds_internal[0]);
        end
        drive(1'b0, 1'b1, rnd_words());
        checks++;
        if (tmds_internal_inv !== {3{10'b0010101011}}) begin
            errors++;
            $display("FAIL invert_idle: got %h want %h", tmds_internal_inv, {3{10'b0010101011}});
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, rnd_words());
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL async_setup: got state %0d want 2", state);
        end
        #2 reset_n = 1'b0;
        m_active = 1'b0;
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h want %h", obs, exp_vec());
        end
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        checks++;
        if (obs !== exp_vec() || ser_reset !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_hold: got %h want %h", obs, exp_vec());
        end
        reset_n = 1'b1;
        drive(1'b1, 1'b1, rnd_words());
        checks++;
        if (obs !== exp_vec() || state !== 3'd1) begin
            errors++;
            $display("FAIL reset_release_first_edge: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 39) != 0), rnd_words());
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_run_loss();
        test_lock_glitch();
        test_enable_warmup();
        test_invert();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
